// File: rtl/seg7_pkg.sv
// Shared types and segment constants for the seg7 display codebase.
// Segment bit order is a..g with bit6=a and bit0=g; 1 means the segment is lit.
package seg7_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_DIGIT [0:9] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
        7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B
    };

    // Non-decimal nibbles light only the middle bar.
    localparam seg_t SEG_DASH = 7'b0000001;
    localparam seg_t SEG_OFF  = 7'b0000000;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Load/ready handshake bundle carrying a packed BCD word and decimal points.
// The master drives the data, and the scan driver (slave) answers with ready.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load;
    logic                      ready;
    logic [4*NUM_DIGITS-1:0]   bcd_in;
    logic [NUM_DIGITS-1:0]     dp_in;

    modport master (output load, output bcd_in, output dp_in, input ready);
    modport slave  (input load, input bcd_in, input dp_in, output ready);
endinterface

// File: rtl/seg7_bcd_encode.sv
// Combinational BCD nibble to 7-segment pattern (a..g, active-high).
// Nibbles 10..15 are shown as a dash.
module seg7_bcd_encode
    import seg7_pkg::*;
(
    input  bcd_t bcd,
    output seg_t seg
);

    // Table lookup for decimal digits, and a dash for everything else.
    always_comb begin
        // NOTE: give every combinational output a default first so no path leaves it unassigned (latch).
        seg = SEG_DASH;
        if (bcd <= 4'd9) begin
            seg = SEG_DIGIT[bcd];
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a common-cathode 7-segment display.
// A loaded value waits in a shadow register and reaches the active register
// only at a frame boundary, so a frame never mixes old and new digits.
// Optional build macro SEG7_LZ_BLANK_EN turns on leading-zero suppression.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seg7_scan_driver_if.slave      bus,
    input  logic                   blank,
    output seg_t                   seg,
    output logic                   dp,
    output logic [NUM_DIGITS-1:0]  digit_sel
);

    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_GUARD = PRE_W'(GUARD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]             pre, pre_nxt;
    logic [IDX_W-1:0]             idx, idx_nxt;
    bcd_t [NUM_DIGITS-1:0]        shadow, active, active_nxt;
    logic [NUM_DIGITS-1:0]        shadow_dp, active_dp, active_dp_nxt;
    logic                         pending;
    logic                         slot_end, frame_end, accept, commit;
    seg_t                         enc_seg, seg_nxt;

    assign slot_end  = (pre == PRE_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);
    assign accept    = bus.load && !pending;
    assign commit    = frame_end && pending;
    assign bus.ready = !pending;

    // Next scan position: prescaler wraps per slot, digit index wraps per frame.
    always_comb begin
        pre_nxt = pre + PRE_W'(1);
        idx_nxt = idx;
        if (slot_end) begin
            pre_nxt = '0;
            idx_nxt = frame_end ? '0 : idx + IDX_W'(1);
        end
    end

    assign active_nxt    = commit ? shadow    : active;
    assign active_dp_nxt = commit ? shadow_dp : active_dp;

    // Scan counters, handshake capture and frame-aligned commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre       <= '0;
            idx       <= '0;
            // NOTE: shadow and active are reset so the display shows a defined 0000 after reset.
            shadow    <= '0;
            shadow_dp <= '0;
            active    <= '0;
            active_dp <= '0;
            pending   <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            pre       <= pre_nxt;
            idx       <= idx_nxt;
            active    <= active_nxt;
            active_dp <= active_dp_nxt;
            if (accept) begin
                shadow    <= bus.bcd_in;
                shadow_dp <= bus.dp_in;
                pending   <= 1'b1;
            end else if (commit) begin
                pending   <= 1'b0;
            end
        end
    end

    seg7_bcd_encode u_encode (
        .bcd (active_nxt[idx_nxt]),
        .seg (enc_seg)
    );

`ifdef SEG7_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_dark;

    // A digit above 0 goes dark when it and every higher digit are zero with no dp.
    always_comb begin
        logic all_zero;
        lz_dark  = '0;
        all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            all_zero   = all_zero && (active_nxt[i] == '0) && !active_dp_nxt[i];
            lz_dark[i] = all_zero;
        end
    end

    assign seg_nxt = lz_dark[idx_nxt] ? SEG_OFF : enc_seg;
`else
    assign seg_nxt = enc_seg;
`endif

    // Registered display outputs, aligned with the scan state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg       <= SEG_OFF;
            dp        <= 1'b0;
            digit_sel <= '0;
        end else if (blank) begin
            seg       <= SEG_OFF;
            dp        <= 1'b0;
            digit_sel <= '0;
        end else begin
            seg       <= seg_nxt;
            dp        <= active_dp_nxt[idx_nxt];
            digit_sel <= (pre_nxt >= PRE_GUARD) ? (NUM_DIGITS'(1) << idx_nxt) : '0;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (NUM_DIGITS=4, REFRESH_DIV=8,
// GUARD_CYCLES=2). Accepted loads push the expected frame onto a scoreboard
// queue; it is popped when the commit is observed and compared every cycle.
module tb_seg7_scan_driver;
    import seg7_pkg::*;

    localparam int ND    = 4;
    localparam int RD    = 8;
    localparam int GC    = 2;
    localparam int FRAME = ND * RD;

    typedef struct packed {
        logic [3:0][6:0] seg;
        logic [3:0]      dp;
    } disp_t;

    typedef struct {
        logic [15:0]     bcd;
        logic [3:0]      dp_in;
        logic [3:0][6:0] seg_full;
        logic [3:0][6:0] seg_lz;
    } vec_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       blank = 1'b0;
    seg_t       seg;
    logic       dp;
    logic [3:0] digit_sel;

    seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .GUARD_CYCLES (GC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .blank     (blank),
        .seg       (seg),
        .dp        (dp),
        .digit_sel (digit_sel)
    );

    always #5 clk = ~clk;

    int    n_pass   = 0;
    int    n_checks = 0;
    int    pos      = 0;
    bit    model_pending = 1'b0;
    disp_t cur;
    disp_t sb_q [$];
    vec_t  vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at pos %0d t=%0t", name, act, exp, pos, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        pos++;
    endtask

    function automatic disp_t mk_disp(input vec_t v);
        disp_t d;
`ifdef SEG7_LZ_BLANK_EN
        d.seg = v.seg_lz;
`else
        d.seg = v.seg_full;
`endif
        d.dp = v.dp_in;
        return d;
    endfunction

    function automatic logic [11:0] exp_out(input int p, input disp_t d);
        int         slot;
        int         ph;
        logic [3:0] dsel;
        slot = (p / RD) % ND;
        ph   = p % RD;
        dsel = (ph >= GC) ? (4'b0001 << slot) : 4'b0000;
        return {dsel, d.seg[slot], d.dp[slot]};
    endfunction

    function automatic logic [11:0] act_out();
        return {digit_sel, seg, dp};
    endfunction

    task automatic verify_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            check("disp", act_out(), exp_out(pos, cur));
            tick();
        end
    endtask

    task automatic do_load(input logic [15:0] bcd, input logic [3:0] dpv, input disp_t exp);
        bit accepted;
        check("ready_before_load", bus.ready, !model_pending);
        accepted    = !model_pending;
        bus.load    = 1'b1;
        bus.bcd_in  = bcd;
        bus.dp_in   = dpv;
        tick();
        bus.load    = 1'b0;
        if (accepted) begin
            sb_q.push_back(exp);
            model_pending = 1'b1;
        end
        check("ready_after_load", bus.ready, 1'b0);
    endtask

    task automatic wait_commit();
        int k = 0;
        while (bus.ready !== 1'b1 && k < 3 * FRAME) begin
            tick();
            k++;
        end
        check("commit_timeout", bus.ready, 1'b1);
        if (bus.ready === 1'b1) begin
            pos           = 0;
            model_pending = 1'b0;
            check("sb_nonempty", sb_q.size() != 0, 1'b1);
            if (sb_q.size() != 0) cur = sb_q.pop_front();
        end
    endtask

    initial begin
        vecs[0] = '{16'h1234, 4'b0000, {7'h30, 7'h6D, 7'h79, 7'h33}, {7'h30, 7'h6D, 7'h79, 7'h33}};
        vecs[1] = '{16'h00A5, 4'b0010, {7'h7E, 7'h7E, 7'h01, 7'h5B}, {7'h00, 7'h00, 7'h01, 7'h5B}};
        vecs[2] = '{16'h0040, 4'b0000, {7'h7E, 7'h7E, 7'h33, 7'h7E}, {7'h00, 7'h00, 7'h33, 7'h7E}};
        vecs[3] = '{16'h8765, 4'b1001, {7'h7F, 7'h70, 7'h5F, 7'h5B}, {7'h7F, 7'h70, 7'h5F, 7'h5B}};
        vecs[4] = '{16'hFEDC, 4'b0000, {7'h01, 7'h01, 7'h01, 7'h01}, {7'h01, 7'h01, 7'h01, 7'h01}};
        vecs[5] = '{16'h0000, 4'b0000, {7'h7E, 7'h7E, 7'h7E, 7'h7E}, {7'h00, 7'h00, 7'h00, 7'h7E}};
        vecs[6] = '{16'h0900, 4'b0000, {7'h7E, 7'h7B, 7'h7E, 7'h7E}, {7'h00, 7'h7B, 7'h7E, 7'h7E}};
        vecs[7] = '{16'h0003, 4'b0100, {7'h7E, 7'h7E, 7'h7E, 7'h79}, {7'h00, 7'h7E, 7'h7E, 7'h79}};
        vecs[8] = '{16'h6802, 4'b0001, {7'h5F, 7'h7F, 7'h7E, 7'h6D}, {7'h5F, 7'h7F, 7'h7E, 7'h6D}};
        vecs[9] = '{16'h2B19, 4'b0000, {7'h6D, 7'h01, 7'h30, 7'h7B}, {7'h6D, 7'h01, 7'h30, 7'h7B}};

        bus.load   = 1'b0;
        bus.bcd_in = '0;
        bus.dp_in  = '0;
        cur        = mk_disp(vecs[5]);

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("reset_outputs", act_out(), 12'h000);
        check("reset_ready", bus.ready, 1'b1);
        rst_n = 1'b1;

        // Table: load each vector at a varying phase, then verify one full frame.
        for (int i = 0; i < 10; i++) begin
            repeat ((i * 5) % FRAME) tick();
            do_load(vecs[i].bcd, vecs[i].dp_in, mk_disp(vecs[i]));
            wait_commit();
            verify_cycles(FRAME);
        end

        // Load accepted on the frame-boundary edge commits one frame later.
        repeat (FRAME - 1) tick();
        do_load(vecs[0].bcd, vecs[0].dp_in, mk_disp(vecs[0]));
        pos = 0;
        verify_cycles(FRAME - 1);
        check("boundary_load_still_pending", bus.ready, 1'b0);
        verify_cycles(1);
        wait_commit();
        check("boundary_commit_pos", pos, 0);
        verify_cycles(FRAME);

        // Load while busy is ignored; the first value stays for two frames.
        do_load(vecs[8].bcd, vecs[8].dp_in, mk_disp(vecs[8]));
        do_load(16'h9999, 4'b1111, mk_disp(vecs[4]));
        wait_commit();
        verify_cycles(2 * FRAME);
        check("ignored_load_not_queued", sb_q.size(), 0);
        check("ready_after_ignored", bus.ready, 1'b1);

        // Blank mid-frame with a load during the blanked window.
        repeat (5) tick();
        blank = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 8) do_load(vecs[1].bcd, vecs[1].dp_in, mk_disp(vecs[1]));
            else tick();
            check("blank_dark", act_out(), 12'h000);
        end
        blank = 1'b0;
        tick();
        verify_cycles(FRAME - pos);
        wait_commit();
        check("blank_scan_aligned", pos, 0);
        verify_cycles(FRAME);

        // Reset while a load is pending at digit 2: pending value is lost.
        repeat (16) tick();
        do_load(16'h5555, 4'b0000, mk_disp(vecs[4]));
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", act_out(), 12'h000);
        check("midreset_ready", bus.ready, 1'b1);
        repeat (3) @(negedge clk);
        check("midreset_hold", act_out(), 12'h000);
        rst_n = 1'b1;
        sb_q.delete();
        model_pending = 1'b0;
        cur = mk_disp(vecs[5]);
        pos = 0;
        check("post_reset_first", act_out(), 12'h000);
        tick();
        verify_cycles(2 * FRAME - 1);
        check("post_reset_ready", bus.ready, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Time-multiplexed driver for an NUM_DIGITS-digit common-cathode 7-segment display. It accepts a packed BCD word through a load/ready handshake and holds it in a shadow register. The shadow register is committed to the active register only at frame boundaries, so no frame ever shows a mix of old and new digits. It scans the digits round-robin, drives one-hot digit selects with an anti-ghosting guard interval, and encodes each nibble into segments (bit6=a … bit0=g, active-high).

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
REFRESH_DIV, 1000, clk cycles per digit slot (must exceed GUARD_CYCLES)
GUARD_CYCLES, 2, cycles at the start of each slot during which digit_sel is forced to 0

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
load  input  1  request to capture bcd_in/dp_in; accepted only when ready=1
ready  output  1  1 = no commit pending, load will be accepted
bcd_in  input  4*NUM_DIGITS  packed BCD; bits [3:0] = digit 0 (least significant)
dp_in  input  NUM_DIGITS  decimal-point request per digit
blank  input  1  active-high; forces display dark, scanning continues
seg  output  7  segments a..g (bit6=a), 1 = lit
dp  output  1  decimal point of the currently selected digit
digit_sel  output  NUM_DIGITS  one-hot digit enable, 1 = on

Behaviour:
- Reset (async assert, sync release): pre=0, idx=0, shadow/active/dp regs=0, pending=0; outputs seg=0, dp=0, digit_sel=0, ready=1.
- State: prescaler pre counts 0..REFRESH_DIV-1. At pre=REFRESH_DIV-1, pre wraps to 0 and idx advances, wrapping at NUM_DIGITS-1 to 0.
- Frame boundary: the edge where pre=REFRESH_DIV-1 and idx=NUM_DIGITS-1.
- Outputs are registered from next-state. In the cycle where state is (pre,idx):
  - digit_sel = onehot(idx) if pre>=GUARD_CYCLES, else 0
  - seg = encode(active[idx]); dp = active_dp[idx]
- blank=1 sampled at edge k: seg, dp and digit_sel are 0 from edge k while blank stays 1. pre/idx keep counting. The load handshake is unaffected.
- Encoding: 0..9 → 7E,30,6D,79,33,5B,5F,70,7F,7B (hex, a..g). 10..15 → dash 7'b0000001.
- Handshake:
  - load=1 with ready=1 captures shadow/shadow_dp and sets pending; ready=0 from the next cycle.
  - load while ready=0 is ignored (no capture, no error).
- Commit: at the frame boundary with pending=1, active<=shadow and pending<=0, so ready=1 next cycle. The new value is shown from digit 0 of the next frame.
- Load accepted on the frame-boundary edge itself: captured, but commits at the following boundary, not this one.
- Worst-case load→display latency: NUM_DIGITS*REFRESH_DIV+1 cycles.
- Reset asserted mid-frame/mid-pending: everything returns to reset values; the pending value is lost.

Optional Feature:
SEG7_LZ_BLANK_EN
- Defined: leading-zero suppression. Digit i (i>0) is dark (seg=0) when active[j]==0 and active_dp[j]==0 for all j>=i. Digit 0 is always shown. digit_sel timing is unchanged.
- Undefined: all digits are always encoded.

Decomposition:
- Package seg7_pkg:
  - bcd_t (4-bit)
  - SEG_DIGIT[0:9] constants, SEG_DASH=7'b0000001, SEG_OFF=7'b0
- Sub-module seg7_bcd_encode: purely combinational bcd_t→7-bit using the package constants.
- seg7_scan_driver instantiates one encoder on the muxed nibble.

Test Plan:
All cases use NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2.
1. Reset, load bcd_in=16'h1234 → ready drops next cycle and rises after the first frame boundary. Next frame shows:
   - slot0: cycles 0-1 digit_sel=0000, cycles 2-7 digit_sel=0001, seg=7'b0110011
   - slot3: seg=7'b0110000, digit_sel=1000
2. Load 16'h1234, then load 16'h9999 while ready=0 → the second load is ignored; the displayed value stays 1234 for all subsequent frames.
3. Load 16'h00A5, dp_in=4'b0010 → digit1 seg=7'b0000001 with dp=1; digit0 seg=7'b1011011.
4. blank=1 for 20 cycles mid-frame → seg/digit_sel=0 throughout. Scan position after release equals an unblanked reference count.
5. rst_n low for 3 cycles while pending and at idx=2 → outputs 0, ready=1. After release, the display shows 0000 (7E on each digit) until the next load commits.
6. Load 16'h0040:
   - With SEG7_LZ_BLANK_EN: digits 3 and 2 seg=0; digit1 seg=7'b0110011; digit0 seg=7'b1111110.
   - Without it: digit3 seg=7'b1111110.
